sram_wr_arbiter: RTL and testbench
==================================

# sram_wr_arbiter

Sits between the SPI command decoder and the single-port frame SRAM. It turns pixel write requests into SRAM writes by walking a column/row window cursor, and buffers those writes in a small FIFO. It also runs full-frame clears and shares the SRAM port with the HDMI scan-out read path, where reads always win.

## Interface
Parameters:
- H_RES, 320, frame width in pixels (row stride)
- V_RES, 240, frame height in pixels
- ADDR_W, 17, SRAM word address width; H_RES*V_RES <= 2**ADDR_W
- FIFO_DEPTH, 4, write FIFO entries (power of two)

Ports:
- i_clk  in  1  system clock (single clock domain)
- i_rst_n  in  1  asynchronous active-low reset
- i_pixel_data  in  16  RGB565 pixel for i_write_req
- i_col_addr  in  32  XS=[31:16], XE=[15:0]
- i_row_addr  in  32  YS=[31:16], YE=[15:0]
- i_clr_req  in  1  1-cycle pulse: clear whole frame to 0
- i_write_req  in  1  1-cycle pulse: write i_pixel_data at cursor
- i_waddr_set_req  in  1  1-cycle pulse: reload cursor to (XS,YS)
- i_rd_req  in  1  scan-out read request, 1-cycle
- i_rd_addr  in  ADDR_W  scan-out read address
- o_rd_data  out  16  read data
- o_rd_valid  out  1  o_rd_data valid, 1-cycle pulse
- o_mem_en  out  1  SRAM access enable
- o_mem_we  out  1  SRAM write enable (qualified by o_mem_en)
- o_mem_addr  out  ADDR_W  SRAM address
- o_mem_wdata  out  16  SRAM write data
- i_mem_rdata  in  16  SRAM read data, 1 cycle after read access
- o_busy  out  1  high while in CLEAR
- o_overflow  out  1  sticky: a write was dropped because the FIFO was full

## Operation
- Cursor registers x, y are 16 bits each.
- On i_waddr_set_req: x<=XS, y<=YS.
- On i_write_req the target is (x,y), or (XS,YS) if i_waddr_set_req is in the same cycle.
- After each i_write_req the cursor advances:
  - if x==XE: x<=XS, and y<=(y==YE ? YS : y+1)
  - else x<=x+1
- Degenerate windows: if XS>XE, treat XE as XS; if YS>YE, treat YE as YS.
- Clipping: a write with x>=H_RES or y>=V_RES is discarded, and the cursor still advances.
- Address: y*H_RES+x, computed modulo 2**ADDR_W, and enqueued with the pixel data.
- FIFO full on i_write_req: the write is dropped, the cursor still advances, and o_overflow<=1.
- o_overflow is cleared only by i_clr_req or reset.
- States:
  - IDLE: a write may be popped from the FIFO.
  - CLEAR: a counter c runs 0..H_RES*V_RES-1, writing 0 at address c. At the last address it returns to IDLE.
- i_clr_req in any state:
  - flushes the FIFO
  - sets c<=0 and enters CLEAR (a clear already in progress restarts)
  - sets o_overflow<=0
  - leaves the cursor unchanged
- i_write_req while in CLEAR or in the i_clr_req cycle: the cursor advances and nothing is enqueued.
- Per-cycle port arbitration, strict priority:
  1. i_rd_req: read i_rd_addr
  2. CLEAR step: write 0, c advances
  3. FIFO non-empty: pop and write
  4. otherwise: no access
- Losing requesters wait; the read is never delayed.
- Push and pop may happen in the same cycle; occupancy is unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, x=y=c=0.
- o_mem_* are registered. An arbitration decision in cycle N is driven on o_mem_* in cycle N+1, with o_mem_en=1 only for that cycle.
- Read: i_rd_req at N -> o_mem_en=1/we=0 at N+1 -> i_mem_rdata at N+2 -> o_rd_data/o_rd_valid registered at N+3. Latency is fixed at 3 and back-to-back reads are fully pipelined.
- Write: i_write_req at N -> enqueued at end of N -> popped at N+1 if no read -> o_mem_we=1 at N+2.
- Clear:
  - i_clr_req at N -> CLEAR and o_busy=1 from N+1, first write on o_mem_* at N+2.
  - H_RES*V_RES cycles with no read contention.
  - o_busy falls the cycle after the last address is issued.
- Reset asserted mid-operation: immediate return to reset values, with no partial write issued after reset.

## Test plan
- Reset, then idle: all outputs 0. i_rd_req with addr 5 and i_mem_rdata=16'h1234 at N+2 -> o_rd_valid and o_rd_data=16'h1234 at N+3.
- CASET 10..12, RASET 3..4, six writes of 1..6 -> SRAM writes at addresses 970,971,972,1290,1291,1292. A seventh write goes to 970.
- Continuous i_rd_req plus 5 back-to-back writes with FIFO_DEPTH=4 -> fifth write dropped, o_overflow=1, zero writes issued. Releasing i_rd_req -> 4 writes drain in order.
- Window XS=318..321 at y=0, 4 writes -> writes only to addresses 318 and 319. The cursor then returns to x=318 at y=1 (window YE>=1).
- i_clr_req with H_RES=4, V_RES=2 -> o_busy for 8 write cycles with data 0 at addresses 0..7. A read injected mid-clear stalls the clear by exactly one cycle.
- i_clr_req at address 3 of an in-progress clear and i_write_req during CLEAR -> clear restarts at 0, nothing is enqueued, and the cursor is advanced.

Source files
------------

// File: rtl/sram_wr_arbiter.sv
// Frame SRAM port arbiter: windowed pixel writes through a small FIFO,
// full-frame clears, and scan-out reads that always win the port.
module sram_wr_arbiter #(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_pixel_data,
  input  logic [31:0]       i_col_addr,
  input  logic [31:0]       i_row_addr,
  input  logic              i_clr_req,
  input  logic              i_write_req,
  input  logic              i_waddr_set_req,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [15:0]       o_rd_data,
  output logic              o_rd_valid,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  input  logic [15:0]       i_mem_rdata,
  output logic              o_busy,
  output logic              o_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TOTAL = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(TOTAL - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [15:0]       x, y;
  logic [ADDR_W-1:0] c;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [PTR_W:0]    count;
  logic              rd_p1, rd_p2;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [15:0]       fifo_data [FIFO_DEPTH];

  logic [15:0]       xs, xe, ys, ye, cur_x, cur_y, nxt_x, nxt_y;
  logic [ADDR_W-1:0] lin_addr;
  logic              in_frame, accept, fifo_full, push, drop;
  logic              do_rd, do_clr, do_pop;

  // Window bounds with degenerate ranges collapsed onto the start coordinate
  always_comb begin
    xs    = i_col_addr[31:16];
    ys    = i_row_addr[31:16];
    xe    = (i_col_addr[15:0] < xs) ? xs : i_col_addr[15:0];
    ye    = (i_row_addr[15:0] < ys) ? ys : i_row_addr[15:0];
    cur_x = i_waddr_set_req ? xs : x;
    cur_y = i_waddr_set_req ? ys : y;
    nxt_x = cur_x + 16'd1;
    nxt_y = cur_y;
    if (cur_x == xe) begin
      nxt_x = xs;
      nxt_y = (cur_y == ye) ? ys : cur_y + 16'd1;
    end
  end

  assign in_frame  = (32'(cur_x) < 32'(H_RES)) && (32'(cur_y) < 32'(V_RES));
  assign lin_addr  = ADDR_W'(32'(cur_y) * 32'(H_RES) + 32'(cur_x));
  assign accept    = i_write_req && !i_clr_req && (state == IDLE) && in_frame;
  assign fifo_full = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign push      = accept && !fifo_full;
  assign drop      = accept && fifo_full;

  // Strict priority: read, clear step, FIFO pop; a clear request cycle only admits reads
  assign do_rd  = i_rd_req;
  assign do_clr = !i_rd_req && !i_clr_req && (state == CLEAR);
  assign do_pop = !i_rd_req && !i_clr_req && (state == IDLE) && (count != '0);

  assign o_busy = (state == CLEAR);

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wptr] <= lin_addr;
      fifo_data[wptr] <= i_pixel_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      c           <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      o_overflow  <= 1'b0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      o_rd_valid  <= 1'b0;
      o_rd_data   <= '0;
    end else begin
      if (i_write_req) begin
        x <= nxt_x;
        y <= nxt_y;
      end else if (i_waddr_set_req) begin
        x <= xs;
        y <= ys;
      end

      if (i_clr_req) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push)   wptr <= wptr + PTR_W'(1);
        if (do_pop) rptr <= rptr + PTR_W'(1);
        if (push && !do_pop)      count <= count + (PTR_W+1)'(1);
        else if (!push && do_pop) count <= count - (PTR_W+1)'(1);
      end

      if (i_clr_req) begin
        state <= CLEAR;
        c     <= '0;
      end else if (do_clr) begin
        if (c == LAST_C) begin
          state <= IDLE;
          c     <= '0;
        end else begin
          c <= c + ADDR_W'(1);
        end
      end

      if (i_clr_req) o_overflow <= 1'b0;
      else if (drop) o_overflow <= 1'b1;

      // Registered SRAM port: decision here is visible next cycle
      o_mem_en <= do_rd || do_clr || do_pop;
      o_mem_we <= do_clr || do_pop;
      if (do_rd) begin
        o_mem_addr <= i_rd_addr;
      end else if (do_clr) begin
        o_mem_addr  <= c;
        o_mem_wdata <= '0;
      end else if (do_pop) begin
        o_mem_addr  <= fifo_addr[rptr];
        o_mem_wdata <= fifo_data[rptr];
      end

      // Read return: access at p1, SRAM data at p2, registered out after
      rd_p1      <= do_rd;
      rd_p2      <= rd_p1;
      o_rd_valid <= rd_p2;
      if (rd_p2) o_rd_data <= i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// Directed bench for sram_wr_arbiter: one default-size instance and one
// 4x2 instance sharing inputs so full clears finish quickly.
module tb_sram_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] pixel_data = '0;
  logic [31:0] col_addr = '0;
  logic [31:0] row_addr = '0;
  logic        clr_req = 1'b0;
  logic        write_req = 1'b0;
  logic        waddr_set_req = 1'b0;
  logic        rd_req = 1'b0;
  logic [16:0] rd_addr = '0;
  logic [15:0] mem_rdata = '0;

  logic [15:0] a_rd_data, b_rd_data, a_wdata, b_wdata;
  logic        a_rd_valid, b_rd_valid, a_en, b_en, a_we, b_we;
  logic        a_busy, b_busy, a_ovf, b_ovf;
  logic [16:0] a_addr, b_addr;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [16:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;
  wr_t qa[$];
  wr_t qb[$];

  sram_wr_arbiter #(.H_RES(320), .V_RES(240), .ADDR_W(17), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(pixel_data),
    .i_col_addr(col_addr), .i_row_addr(row_addr), .i_clr_req(clr_req),
    .i_write_req(write_req), .i_waddr_set_req(waddr_set_req),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(a_rd_data),
    .o_rd_valid(a_rd_valid), .o_mem_en(a_en), .o_mem_we(a_we),
    .o_mem_addr(a_addr), .o_mem_wdata(a_wdata), .i_mem_rdata(mem_rdata),
    .o_busy(a_busy), .o_overflow(a_ovf));

  sram_wr_arbiter #(.H_RES(4), .V_RES(2), .ADDR_W(17), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(pixel_data),
    .i_col_addr(col_addr), .i_row_addr(row_addr), .i_clr_req(clr_req),
    .i_write_req(write_req), .i_waddr_set_req(waddr_set_req),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(b_rd_data),
    .o_rd_valid(b_rd_valid), .o_mem_en(b_en), .o_mem_we(b_we),
    .o_mem_addr(b_addr), .o_mem_wdata(b_wdata), .i_mem_rdata(mem_rdata),
    .o_busy(b_busy), .o_overflow(b_ovf));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_en && a_we) qa.push_back('{a_addr, a_wdata, cyc});
      if (b_en && b_we) qb.push_back('{b_addr, b_wdata, cyc});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop the one-cycle pulses
  task automatic step();
    @(posedge clk);
    #1;
    clr_req       = 1'b0;
    write_req     = 1'b0;
    waddr_set_req = 1'b0;
  endtask

  initial begin
    int unsigned exp2[6];
    logic [15:0] data_or;
    exp2 = '{970, 971, 972, 1290, 1291, 1292};

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {a_en, a_we, a_busy, a_ovf, a_rd_valid}, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wdata, 0);
    chk("rst_rdata", a_rd_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    chk("idle_ctrl", {a_en, a_we, a_busy, a_ovf, a_rd_valid}, 0);

    // Single read, latency 3
    rd_req = 1'b1; rd_addr = 17'd5;
    step(); rd_req = 1'b0;
    @(negedge clk);
    chk("rd_port", {a_en, a_we}, 2'b10);
    chk("rd_addr", a_addr, 5);
    mem_rdata = 16'h1234;
    step(); @(negedge clk);
    chk("rd_valid_n2", a_rd_valid, 0);
    step(); @(negedge clk);
    chk("rd_valid_n3", a_rd_valid, 1);
    chk("rd_data", a_rd_data, 16'h1234);
    step(); @(negedge clk);
    chk("rd_valid_n4", a_rd_valid, 0);

    // Window 10..12 x 3..4, six writes then a seventh that wraps
    qa.delete();
    col_addr = {16'd10, 16'd12}; row_addr = {16'd3, 16'd4};
    waddr_set_req = 1'b1; step();
    for (int i = 1; i <= 6; i++) begin
      write_req = 1'b1; pixel_data = 16'(i); step();
    end
    repeat (3) step();
    chk("win_cnt", qa.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < qa.size()) begin
        chk($sformatf("win_addr%0d", i), qa[i].addr, exp2[i]);
        chk($sformatf("win_data%0d", i), qa[i].data, i + 1);
      end
    end
    write_req = 1'b1; pixel_data = 16'd7; step();
    repeat (3) step();
    chk("wrap_cnt", qa.size(), 7);
    if (qa.size() > 6) chk("wrap_addr", qa[6].addr, 970);

    // Reads hog the port: FIFO fills, fifth write dropped
    qa.delete();
    rd_req = 1'b1; rd_addr = 17'd0;
    waddr_set_req = 1'b1; write_req = 1'b1; pixel_data = 16'hA1; step();
    for (int i = 2; i <= 5; i++) begin
      write_req = 1'b1; pixel_data = 16'hA0 + 16'(i); step();
    end
    step(); step();
    @(negedge clk);
    chk("ovf_set", a_ovf, 1);
    chk("ovf_nowr", qa.size(), 0);
    chk("rd_stream", a_rd_valid, 1);
    rd_req = 1'b0;
    repeat (6) step();
    chk("drain_cnt", qa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < qa.size()) begin
        chk($sformatf("drain_addr%0d", i), qa[i].addr, exp2[i]);
        chk($sformatf("drain_data%0d", i), qa[i].data, 16'hA1 + i);
      end
    end
    chk("ovf_sticky", a_ovf, 1);

    // Clipping at the right frame edge
    qa.delete();
    col_addr = {16'd318, 16'd321}; row_addr = {16'd0, 16'd1};
    waddr_set_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      write_req = 1'b1; pixel_data = 16'hB0 + 16'(i); step();
    end
    repeat (3) step();
    chk("clip_cnt", qa.size(), 3);
    if (qa.size() > 2) begin
      chk("clip_a0", qa[0].addr, 318);
      chk("clip_a1", qa[1].addr, 319);
      chk("clip_a2", qa[2].addr, 638);
      chk("clip_d2", qa[2].data, 16'hB5);
    end

    // Asynchronous reset takes effect without a clock edge
    rst_n = 1'b0;
    #1 chk("async_rst", {a_ovf, a_en}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Full clear of the 4x2 frame
    clr_req = 1'b1; step();
    @(negedge clk);
    chk("clr_busy_n1", {b_busy, b_en}, 2'b10);
    for (int k = 0; k < 8; k++) begin
      step(); @(negedge clk);
      chk($sformatf("clr_port%0d", k), {b_en, b_we}, 2'b11);
      chk($sformatf("clr_addr%0d", k), b_addr, k);
      chk($sformatf("clr_data%0d", k), b_wdata, 0);
      chk($sformatf("clr_busy%0d", k), b_busy, (k < 7));
    end
    step(); @(negedge clk);
    chk("clr_done_en", b_en, 0);

    // Read injected mid-clear stalls it by one cycle
    qb.delete();
    clr_req = 1'b1; step();
    step(); step();
    rd_req = 1'b1; rd_addr = 17'd1;
    step(); rd_req = 1'b0;
    @(negedge clk);
    chk("clr_rd_port", {b_en, b_we}, 2'b10);
    chk("clr_rd_addr", b_addr, 1);
    repeat (8) step();
    chk("clr_rd_cnt", qb.size(), 8);
    if (qb.size() > 7) begin
      chk("clr_rd_span", qb[7].cyc - qb[0].cyc, 8);
      chk("clr_rd_last", qb[7].addr, 7);
      chk("clr_rd_a2", qb[2].addr, 2);
    end
    chk("clr_rd_busy", b_busy, 0);

    // Restart during clear; writes in CLEAR only move the cursor
    col_addr = {16'd0, 16'd3}; row_addr = {16'd0, 16'd1};
    waddr_set_req = 1'b1; step();
    qb.delete();
    clr_req = 1'b1; step();
    step();
    write_req = 1'b1; pixel_data = 16'hC1; step();
    step();
    clr_req = 1'b1; write_req = 1'b1; pixel_data = 16'hC2; step();
    repeat (10) step();
    chk("rst_clr_cnt", qb.size(), 11);
    if (qb.size() > 10) begin
      chk("rst_clr_a2", qb[2].addr, 2);
      chk("rst_clr_a3", qb[3].addr, 0);
      chk("rst_clr_gap", qb[3].cyc - qb[2].cyc, 2);
      chk("rst_clr_a10", qb[10].addr, 7);
    end
    data_or = '0;
    foreach (qb[i]) data_or = data_or | qb[i].data;
    chk("rst_clr_zero", data_or, 0);
    write_req = 1'b1; pixel_data = 16'hC3; step();
    repeat (3) step();
    chk("cursor_cnt", qb.size(), 12);
    if (qb.size() > 11) begin
      chk("cursor_addr", qb[11].addr, 2);
      chk("cursor_data", qb[11].data, 16'hC3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
